// File: rtl/vpu_operand_queue.sv
// Per-operand FWFT queue between the VPU source port controller and the vector lanes.
// Define VPU_OPQ_ERR_EN to build the sticky overflow/underflow flags on err_o.
module vpu_operand_queue #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DEPTH_LG2  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  wren_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  wrfull_o,
  output logic                  wrempty_o,
  input  logic                  rden_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rdempty_o,
  output logic [DEPTH_LG2:0]    count_o,
  output logic [1:0]            err_o
);

  localparam logic [DEPTH_LG2:0] CntFull = (DEPTH_LG2 + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LG2-1:0]  wptr_q, wptr_d;
  logic [DEPTH_LG2-1:0]  rptr_q, rptr_d;
  logic [DEPTH_LG2:0]    count_q, count_d;
  logic                  full, empty, wr_acc, rd_acc;

  assign full   = (count_q == CntFull);
  assign empty  = (count_q == '0);
  // Acceptance uses the pre-edge count, so a full queue pops but never pushes in one cycle.
  assign wr_acc = wren_i && !full;
  assign rd_acc = rden_i && !empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_acc) wptr_d = wptr_q + DEPTH_LG2'(1);
    if (rd_acc) rptr_d = rptr_q + DEPTH_LG2'(1);
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (DEPTH_LG2 + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LG2 + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i && wr_acc) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o   = mem_q[rptr_q];
  assign rdempty_o = empty;
  assign wrempty_o = empty;
  assign wrfull_o  = full;
  assign count_o   = count_q;

`ifdef VPU_OPQ_ERR_EN
  logic [1:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (wren_i && full)  err_d[1] = 1'b1;
    if (rden_i && empty) err_d[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      err_q <= 2'b00;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && !flush_i) begin
      assert (!(wren_i && full)) else $warning("vpu_operand_queue: write while full");
      assert (!(rden_i && empty)) else $warning("vpu_operand_queue: read while empty");
    end
  end
`endif
`else
  assign err_o = 2'b00;
`endif

endmodule

// File: tb/tb_vpu_operand_queue.sv
// Directed self-checking bench for vpu_operand_queue (default DEPTH=4, 256-bit rows).
module tb_vpu_operand_queue;

  localparam int unsigned DW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_i;
  logic          wren_i;
  logic [DW-1:0] wdata_i;
  logic          wrfull_o;
  logic          wrempty_o;
  logic          rden_i;
  logic [DW-1:0] rdata_o;
  logic          rdempty_o;
  logic [2:0]    count_o;
  logic [1:0]    err_o;

  int n_checks = 0;
  int n_errors = 0;

`ifdef VPU_OPQ_ERR_EN
  localparam logic [1:0] ErrOvf = 2'b10;
  localparam logic [1:0] ErrUnf = 2'b01;
`else
  localparam logic [1:0] ErrOvf = 2'b00;
  localparam logic [1:0] ErrUnf = 2'b00;
`endif

  vpu_operand_queue dut (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush_i),
    .wren_i    (wren_i),
    .wdata_i   (wdata_i),
    .wrfull_o  (wrfull_o),
    .wrempty_o (wrempty_o),
    .rden_i    (rden_i),
    .rdata_o   (rdata_o),
    .rdempty_o (rdempty_o),
    .count_o   (count_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle with the given strobes; outputs sampled 1 time unit after the edge.
  task automatic cycle(input logic wr, input logic [DW-1:0] d, input logic rd, input logic fl);
    wren_i  = wr;
    wdata_i = d;
    rden_i  = rd;
    flush_i = fl;
    @(posedge clk);
    #1;
    wren_i  = 1'b0;
    rden_i  = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic [2:0] cnt, input logic [1:0] err);
    check_eq({tag, "_count"}, DW'(count_o), DW'(cnt));
    check_eq({tag, "_rdempty"}, DW'(rdempty_o), DW'(cnt == 3'd0));
    check_eq({tag, "_wrempty"}, DW'(wrempty_o), DW'(cnt == 3'd0));
    check_eq({tag, "_wrfull"}, DW'(wrfull_o), DW'(cnt == 3'd4));
    check_eq({tag, "_err"}, DW'(err_o), DW'(err));
  endtask

  logic [DW-1:0] row [1:7];
  logic [DW-1:0] d, d_prev;

  initial begin
    rst = 1'b1; flush_i = 1'b0; wren_i = 1'b0; rden_i = 1'b0; wdata_i = '0;
    for (int i = 1; i <= 7; i++) row[i] = {8{32'h1234_0000 | 32'(i)}};
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    cycle(1'b0, '0, 1'b0, 1'b0);
    check_flags("reset", 3'd0, 2'b00);

    // Single write shows at the head the next cycle
    cycle(1'b1, {64{4'hA}}, 1'b0, 1'b0);
    check_flags("wr1", 3'd1, 2'b00);
    check_eq("wr1_rdata", rdata_o, {64{4'hA}});
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_flags("pop1", 3'd0, 2'b00);

    // Fill, then overflow write is dropped
    for (int i = 1; i <= 4; i++) cycle(1'b1, row[i], 1'b0, 1'b0);
    check_flags("fill4", 3'd4, 2'b00);
    check_eq("fill4_head", rdata_o, row[1]);
    cycle(1'b1, row[5], 1'b0, 1'b0);
    check_flags("ovf", 3'd4, ErrOvf);
    check_eq("ovf_head", rdata_o, row[1]);

    // Full plus simultaneous read/write: pop only
    cycle(1'b1, row[6], 1'b1, 1'b0);
    check_flags("full_rw", 3'd3, ErrOvf);
    for (int i = 2; i <= 4; i++) begin
      check_eq($sformatf("drain_head%0d", i), rdata_o, row[i]);
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    check_flags("drained", 3'd0, ErrOvf);

    // Empty plus simultaneous read/write: push only
    cycle(1'b1, row[7], 1'b1, 1'b0);
    check_flags("empty_rw", 3'd1, ErrOvf);
    check_eq("empty_rw_head", rdata_o, row[7]);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_flags("empty_rw_pop", 3'd0, ErrOvf);

    // Streaming across pointer wrap
    d = {8{32'hC0DE_0000}};
    cycle(1'b1, d, 1'b0, 1'b0);
    check_eq("wrap_head0", rdata_o, d);
    for (int i = 1; i < 10; i++) begin
      d_prev = d;
      d = {8{32'hC0DE_0000 | 32'(i)}};
      check_eq($sformatf("wrap_pre%0d", i), rdata_o, d_prev);
      cycle(1'b1, d, 1'b1, 1'b0);
      check_eq($sformatf("wrap_cnt%0d", i), DW'(count_o), DW'(3'd1));
      check_eq($sformatf("wrap_head%0d", i), rdata_o, d);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_flags("wrap_end", 3'd0, ErrOvf);

    // Flush with a concurrent write clears everything including err
    for (int i = 1; i <= 3; i++) cycle(1'b1, row[i], 1'b0, 1'b0);
    check_flags("pre_flush", 3'd3, ErrOvf);
    cycle(1'b1, row[4], 1'b0, 1'b1);
    check_flags("flush", 3'd0, 2'b00);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_flags("unf", 3'd0, ErrUnf);
    cycle(1'b1, row[5], 1'b0, 1'b0);
    check_flags("post_flush_wr", 3'd1, ErrUnf);
    check_eq("post_flush_head", rdata_o, row[5]);

    // Reset mid-operation empties the queue
    cycle(1'b1, row[6], 1'b0, 1'b0);
    rst = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    check_flags("mid_reset", 3'd0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vpu_operand_queue.md
Name: vpu_operand_queue

Overview:
- Per-source-operand FIFO between the VPU source port controller and the vector lanes.
- Write side takes one SRAM row (wdata/wren pulse) per fetch; read side presents operands first-word-fall-through to the lane/execute stage.
- Reports full/empty back to the source port controller and occupancy to the VPU controller.
- Flushed by the controller's per-instruction reset command.

Parameters:
- DATA_WIDTH, 256, width of one operand row (DIM_SIZE = 16 lanes x 16 bit).
- DEPTH, 4, number of entries; must be a power of two, >= 2.
- DEPTH_LG2, $clog2(DEPTH), pointer width.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush_i  input  1  synchronous clear of pointers and count (the controller's reset_cmd); storage contents are not cleared.
- wren_i  input  1  write strobe, one entry per cycle.
- wdata_i  input  DATA_WIDTH  write data.
- wrfull_o  output  1  queue holds DEPTH entries.
- wrempty_o  output  1  queue holds 0 entries; same value as rdempty_o.
- rden_i  input  1  pop strobe, one entry per cycle.
- rdata_o  output  DATA_WIDTH  head entry, valid whenever rdempty_o=0.
- rdempty_o  output  1  no data available.
- count_o  output  DEPTH_LG2+1  current occupancy, 0..DEPTH.
- err_o  output  2  {overflow, underflow} sticky flags (see Optional Feature).

Behaviour:
- Storage is DEPTH x DATA_WIDTH registers, with write pointer wptr, read pointer rptr (DEPTH_LG2 bits each, wrap modulo DEPTH) and count (DEPTH_LG2+1 bits).
- Reset (rst=1): wptr=0, rptr=0, count=0, err_o=0.
  - Outputs after reset: wrfull_o=0, wrempty_o=1, rdempty_o=1, count_o=0.
  - rdata_o is don't-care while empty; memory is not reset.
- Accepted write: wren_i=1 and count<DEPTH.
  - mem[wptr]<=wdata_i, and wptr increments.
- Accepted read: rden_i=1 and count>0.
  - rptr increments; rdata_o is combinationally mem[rptr] (FWFT, zero read latency).
- Write-to-read latency: data written in cycle N appears on rdata_o, with rdempty_o=0, in cycle N+1. There is no combinational bypass from write to read.
- Count update:
  - +1 on an accepted write only.
  - -1 on an accepted read only.
  - Unchanged when both are accepted in the same cycle, or when neither is.
- Flags are decoded from the registered count: wrfull_o=(count==DEPTH), wrempty_o=rdempty_o=(count==0).
- Simultaneous read and write:
  - When full: the read is accepted and the write is rejected, because write acceptance uses the pre-edge count. Count drops to DEPTH-1.
  - When empty: the write is accepted and the read is rejected. Count rises to 1.
- Write while full: dropped; pointers, count and memory unchanged.
- Read while empty: ignored; pointers and count unchanged.
- Flush:
  - flush_i=1 takes effect at the next edge: wptr=rptr=count=0.
  - A concurrent wren_i or rden_i in that cycle is discarded.
  - err_o is also cleared by flush.
- Priority: rst > flush_i > normal operation.
- Reset or flush mid-operation (queue partially full): takes effect at that edge; the next cycle shows an empty queue.

Optional Feature:
- Macro VPU_OPQ_ERR_EN.
- Defined:
  - err_o[1] (overflow) sets on a write attempted while full.
  - err_o[0] (underflow) sets on a read attempted while empty.
  - Both flags are sticky until rst or flush_i.
  - A simulation-only assertion also fires on either event.
- Not defined: err_o is tied to 2'b00 and no error logic is built. Dropping/ignoring behaviour is identical in both builds.

Test Plan:
- Reset, then idle -> wrempty_o=1, rdempty_o=1, wrfull_o=0, count_o=0, err_o=0.
- Write 0xA..A in cycle 0, then no reads -> cycle 1: rdempty_o=0, rdata_o=0xA..A, count_o=1.
- Write 4 distinct rows, then a 5th write -> wrfull_o=1 after the 4th, count_o=4. The 5th row is dropped; reads return rows 1..4 in order. With VPU_OPQ_ERR_EN: err_o=2'b10.
- Full queue plus simultaneous wren_i/rden_i -> head popped, new row dropped, count_o=3. Empty queue plus simultaneous wren_i/rden_i -> count_o=1 and the written row is at the head.
- Wrap-around: continuous 10 writes interleaved with 10 reads (one of each per cycle after the first write) -> data order preserved across pointer wrap, count_o stays at 1.
- Queue holding 3 entries, flush_i pulsed with wren_i=1 -> next cycle count_o=0, rdempty_o=1. A read on an empty queue afterwards -> no state change; err_o=2'b01 with VPU_OPQ_ERR_EN, 2'b00 without.
